// File: rtl/rsa_4k_pkg.sv
// rsa_4k shared constants and FSM encoding.
// Imported by the exponent engine and its modular multiplier.
package rsa_4k_pkg;

    localparam int RSA_WIDTH = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_SQR,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rsa_4k_modmul.sv
// Bit-serial interleaved modular multiplier, p = a*b mod n.
// Scans a MSB-first, WIDTH cycles after the start edge.
module rsa_modmul
    import rsa_4k_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             ready
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH+1:0] r_p;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_ready;

    logic [WIDTH+1:0] w_n;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH+1:0] w_s1;
    logic [WIDTH+1:0] w_s2;

    // 2P + b < 3n, so two conditional subtractions always suffice
    always_comb begin
        w_n   = {2'b00, r_n};
        w_sum = (r_p << 1)
              + (r_a[WIDTH-1] ? {2'b00, r_b} : '0);
        w_s1  = (w_sum >= w_n) ? w_sum - w_n : w_sum;
        w_s2  = (w_s1 >= w_n) ? w_s1 - w_n : w_s1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_n     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (start) begin
                r_a    <= a;
                r_b    <= b;
                r_n    <= n;
                r_p    <= '0;
                r_cnt  <= CW'(WIDTH);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_p   <= w_s2;
                r_a   <= r_a << 1;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            end
        end
    end

    assign p     = r_p[WIDTH-1:0];
    assign ready = r_ready;

endmodule

// File: rtl/rsa_4k.sv
// rsa_4k: cypher = message^exponent mod modulus.
// Right-to-left square-and-multiply over rsa_modmul.
module rsa_4k
    import rsa_4k_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] message,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] cypher,
    output logic             done
);

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_cypher;
    logic             r_done;

    logic             w_mstart;
    logic [WIDTH-1:0] w_ma;
    logic [WIDTH-1:0] w_mb;
    logic [WIDTH-1:0] w_mp;
    logic             w_mready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (go) w_next = ST_NEXT;
            ST_NEXT: begin
                if (r_e == '0)  w_next = ST_DONE;
                else if (r_e[0]) w_next = ST_MUL;
                else            w_next = ST_SQR;
            end
            ST_MUL:  if (w_mready) w_next = ST_SQR;
            ST_SQR:  if (w_mready) w_next = ST_NEXT;
            ST_DONE: if (!go) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // launch on the entering edge so each multiply costs WIDTH+1 cycles
    always_comb begin
        w_mstart = 1'b0;
        w_ma     = r_base;
        w_mb     = r_base;
        if (w_next == ST_MUL && r_state != ST_MUL) begin
            w_mstart = 1'b1;
            w_ma     = r_acc;
        end else if (w_next == ST_SQR && r_state != ST_SQR) begin
            w_mstart = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_base   <= '0;
            r_e      <= '0;
            r_n      <= '0;
            r_cypher <= '0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: if (go) begin
                    r_base <= message;
                    r_e    <= exponent;
                    r_n    <= modulus;
                    r_acc  <= WIDTH'(1);
                    r_done <= 1'b0;
                end
                ST_NEXT: if (r_e == '0) begin
                    r_cypher <= r_acc;
                    r_done   <= 1'b1;
                end
                ST_MUL: if (w_mready) r_acc <= w_mp;
                ST_SQR: if (w_mready) begin
                    r_base <= w_mp;
                    r_e    <= r_e >> 1;
                end
                ST_DONE: if (!go) r_done <= 1'b0;
                default: ;
            endcase
        end
    end

    rsa_modmul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (w_mstart),
        .a     (w_ma),
        .b     (w_mb),
        .n     (r_n),
        .p     (w_mp),
        .ready (w_mready)
    );

    assign cypher = r_cypher;
    assign done   = r_done;

endmodule

// File: tb/tb_rsa_4k.sv
// Self-checking bench for rsa_4k: 16-bit instance for function,
// 1024-bit instance for a wide e=65537 run against a bignum model.
module tb_rsa_4k;

    localparam int SW = 16;
    localparam int BW = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          go_s, go_b;
    logic [SW-1:0] msg_s, exp_s, mod_s, cy_s;
    logic [BW-1:0] msg_b, exp_b, mod_b, cy_b;
    logic          done_s, done_b;

    int checks   = 0;
    int failures = 0;

    logic [SW-1:0] en_s, eh_s;
    logic [BW-1:0] en_b, eh_b;

    rsa_4k #(.WIDTH(SW)) u_dut (
        .clk(clk), .reset(reset), .go(go_s),
        .message(msg_s), .exponent(exp_s), .modulus(mod_s),
        .cypher(cy_s), .done(done_s)
    );

    rsa_4k #(.WIDTH(BW)) u_big (
        .clk(clk), .reset(reset), .go(go_b),
        .message(msg_b), .exponent(exp_b), .modulus(mod_b),
        .cypher(cy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // cypher must show the new result while done, else the last one
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (done_s) begin
                if (cy_s !== en_s) begin
                    failures++;
                    $display("FAIL cmp_s_done: cypher=%0d expected=%0d",
                             cy_s, en_s);
                end
                eh_s = en_s;
            end else if (cy_s !== eh_s) begin
                failures++;
                $display("FAIL cmp_s_hold: cypher=%0d expected=%0d",
                         cy_s, eh_s);
            end
            checks++;
            if (done_b) begin
                if (cy_b !== en_b) begin
                    failures++;
                    $display("FAIL cmp_b_done: low64=%h expected=%h",
                             cy_b[63:0], en_b[63:0]);
                end
                eh_b = en_b;
            end else if (cy_b !== eh_b) begin
                failures++;
                $display("FAIL cmp_b_hold: low64=%h expected=%h",
                         cy_b[63:0], eh_b[63:0]);
            end
        end
    end

    function automatic logic [SW-1:0] ref_small(
        input logic [SW-1:0] m, e, n);
        longint unsigned r;
        r = 1;
        for (int i = SW - 1; i >= 0; i--) begin
            r = (r * r) % n;
            if (e[i]) r = (r * m) % n;
        end
        return r[SW-1:0];
    endfunction

    function automatic logic [BW-1:0] ref_big(
        input logic [BW-1:0] m, n, input logic [31:0] e);
        logic [2*BW-1:0] r, mm, nn;
        mm = {{BW{1'b0}}, m};
        nn = {{BW{1'b0}}, n};
        r  = 1;
        for (int i = 31; i >= 0; i--) begin
            r = (r * r) % nn;
            if (e[i]) r = (r * mm) % nn;
        end
        return r[BW-1:0];
    endfunction

    task automatic chk(input string nm,
                       input longint unsigned got,
                       input longint unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int bound_of(input int k, input int w);
        return 2 * k * (w + 1) + k + 2;
    endfunction

    task automatic wait_s(input int bound);
        int cyc;
        cyc = 0;
        while (!done_s && cyc < bound + 20) begin
            tick;
            cyc++;
        end
        chk("done_s_seen", done_s, 1);
        checks++;
        if (cyc > bound) begin
            failures++;
            $display("FAIL lat_s: cycles=%0d limit=%0d", cyc, bound);
        end
    endtask

    task automatic start_s(input logic [SW-1:0] m, e, n);
        msg_s = m;
        exp_s = e;
        mod_s = n;
        en_s  = ref_small(m, e, n);
        go_s  = 1'b1;
    endtask

    task automatic run_s(input logic [SW-1:0] m, e, n,
                         input string nm);
        int k;
        k = $clog2(int'(e) + 1);
        start_s(m, e, n);
        wait_s(bound_of(k, SW));
        chk(nm, cy_s, en_s);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("done_held", done_s, 1);
        end
        go_s = 1'b0;
        tick;
        chk("done_fall", done_s, 0);
    endtask

    initial begin
        logic [SW-1:0] rm, re, rn;
        int kb, cyc;
        reset = 1'b1;
        go_s  = 1'b0;
        go_b  = 1'b0;
        msg_s = '0; exp_s = '0; mod_s = '0;
        msg_b = '0; exp_b = '0; mod_b = '0;
        en_s  = '0; eh_s = '0;
        en_b  = '0; eh_b = '0;

        chk("model_enc", ref_small(8, 13, 77), 50);
        chk("model_dec", ref_small(50, 37, 77), 8);
        chk("model_e0", ref_small(5, 0, 77), 1);
        chk("model_e1", ref_small(5, 1, 77), 5);
        chk("model_m0", ref_small(0, 7, 77), 0);

        repeat (3) tick;
        chk("rst_done_s", done_s, 0);
        chk("rst_cy_s", cy_s, 0);
        chk("rst_done_b", done_b, 0);
        chk("rst_cy_b", cy_b[63:0], 0);
        reset = 1'b0;
        tick;

        run_s(8, 13, 77, "encrypt");
        chk("enc_lit", cy_s, 50);
        run_s(50, 37, 77, "decrypt");
        chk("dec_lit", cy_s, 8);
        run_s(5, 0, 77, "exp_zero");
        chk("e0_lit", cy_s, 1);
        run_s(5, 1, 77, "exp_one");
        chk("e1_lit", cy_s, 5);
        run_s(0, 7, 77, "msg_zero");
        chk("m0_lit", cy_s, 0);

        start_s(8, 13, 77);
        repeat (10) tick;
        reset = 1'b1;
        go_s  = 1'b0;
        eh_s  = '0;
        eh_b  = '0;
        tick;
        chk("abort_done", done_s, 0);
        chk("abort_cy", cy_s, 0);
        reset = 1'b0;
        tick;
        run_s(8, 13, 77, "after_abort");
        chk("after_abort_lit", cy_s, 50);

        start_s(8, 13, 77);
        repeat (3) tick;
        msg_s = 16'(50);
        exp_s = 16'(37);
        mod_s = 16'(91);
        wait_s(bound_of(4, SW));
        chk("stable_lit", cy_s, 50);
        for (int i = 0; i < 30; i++) begin
            tick;
            chk("no_rerun", done_s, 1);
        end
        go_s = 1'b0;
        tick;
        chk("stable_fall", done_s, 0);

        start_s(50, 37, 77);
        repeat (3) tick;
        go_s = 1'b0;
        wait_s(bound_of(6, SW));
        chk("godrop_lit", cy_s, 8);
        tick;
        chk("godrop_one_cycle", done_s, 0);

        for (int i = 0; i < 20; i++) begin
            rn = 16'($urandom_range(65535, 2));
            rm = 16'($urandom_range(int'(rn) - 1, 0));
            re = 16'($urandom_range(65535, 0));
            if (i % 4 == 0) re = 16'($urandom_range(15, 0));
            run_s(rm, re, rn, "random");
        end

        for (int w = 0; w < BW / 32; w++) begin
            mod_b[w*32 +: 32] = $urandom;
            msg_b[w*32 +: 32] = $urandom;
        end
        mod_b[BW-1] = 1'b1;
        mod_b[0]    = 1'b1;
        msg_b       = msg_b % mod_b;
        msg_b[0]    = 1'b1;
        exp_b       = BW'(65537);
        en_b        = ref_big(msg_b, mod_b, 32'd65537);
        go_b        = 1'b1;
        kb          = 17;
        cyc         = 0;
        while (!done_b && cyc < bound_of(kb, BW) + 20) begin
            tick;
            cyc++;
        end
        chk("done_b_seen", done_b, 1);
        checks++;
        if (cyc > bound_of(kb, BW)) begin
            failures++;
            $display("FAIL lat_b: cycles=%0d limit=%0d",
                     cyc, bound_of(kb, BW));
        end
        checks++;
        if (cy_b !== en_b) begin
            failures++;
            $display("FAIL big_result: low64=%h expected=%h",
                     cy_b[63:0], en_b[63:0]);
        end
        go_b = 1'b0;
        tick;
        chk("big_fall", done_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
